dmem_mmio_responder: RTL and testbench

- Responder on the processor's data-memory port. Sits between the processor's dmem outputs (address, data, wren) and the dmem syncram, and returns q to the processor.
- Addresses in the MMIO page are answered locally: cycle counter, scratch register, status, and an 8-entry transmit FIFO drained by an external valid/ready consumer.
- All other addresses pass straight through to dmem.
- The block and the attached dmem share one clock.

---
 rtl/dmem_mmio_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: dmem pass-through plus a 16-word MMIO page with a cycle counter,
// a scratch register, a status word and a TX FIFO. Define MMIO_IRQ_EN to add the IRQ_EN register and irq.
module dmem_mmio_responder #(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-5:0] MMIO_PAGE  = 8'hFF,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] proc_address,
    input  logic [DATA_W-1:0] proc_data,
    input  logic              proc_wren,
    output logic [DATA_W-1:0] proc_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OFF_CYCLE   = 4'h0;
    localparam logic [3:0] OFF_TX      = 4'h1;
    localparam logic [3:0] OFF_STATUS  = 4'h2;
    localparam logic [3:0] OFF_SCRATCH = 4'h3;
    localparam logic [3:0] OFF_IRQ_EN  = 4'h4;

    logic              is_mmio;
    logic [3:0]        off;
    logic              mmio_wr;
    logic              wr_cycle;
    logic              wr_tx;
    logic              wr_status;
    logic              wr_scratch;

    logic [DATA_W-1:0] cycle_cnt;
    logic [DATA_W-1:0] scratch;
    logic              ovf;
    logic              ovf_next;
    logic              sel_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_next;
    logic [DATA_W-1:0] status_word;
    logic [1:0]        irq_en_rd;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              overflow;

    assign is_mmio    = (proc_address[ADDR_W-1:4] == MMIO_PAGE);
    assign off        = proc_address[3:0];
    assign mmio_wr    = proc_wren & is_mmio;
    assign wr_cycle   = mmio_wr & (off == OFF_CYCLE);
    assign wr_tx      = mmio_wr & (off == OFF_TX);
    assign wr_status  = mmio_wr & (off == OFF_STATUS);
    assign wr_scratch = mmio_wr & (off == OFF_SCRATCH);

    assign mem_address = proc_address;
    assign mem_data    = proc_data;
    assign mem_wren    = proc_wren & ~is_mmio;

    assign proc_q = sel_q ? rdata_q : mem_q;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    assign push     = wr_tx & (~full | pop);
    assign overflow = wr_tx & full & ~pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Overflow set takes priority over a software clear in the same cycle.
    always_comb begin
        ovf_next = ovf;
        if (wr_status && proc_data[8]) begin
            ovf_next = 1'b0;
        end
        if (overflow) begin
            ovf_next = 1'b1;
        end
    end

    always_comb begin
        status_word    = '0;
        status_word[0] = empty;
        status_word[1] = full;
        status_word[5:2] = 4'(count);
        status_word[8] = ovf;
    end

    always_comb begin
        rdata_next = '0;
        case (off)
            OFF_CYCLE:   rdata_next = cycle_cnt;
            OFF_STATUS:  rdata_next = status_word;
            OFF_SCRATCH: rdata_next = scratch;
            OFF_IRQ_EN:  rdata_next = DATA_W'(irq_en_rd);
            default:     rdata_next = '0;
        endcase
    end

    // Storage needs no reset; only pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_cnt <= '0;
            scratch   <= '0;
            ovf       <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            sel_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            cycle_cnt <= wr_cycle ? '0 : cycle_cnt + DATA_W'(1);
            if (wr_scratch) begin
                scratch <= proc_data;
            end
            ovf   <= ovf_next;
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            sel_q   <= is_mmio;
            rdata_q <= is_mmio ? rdata_next : '0;
        end
    end

`ifdef MMIO_IRQ_EN
    logic       wr_irq_en;
    logic [1:0] irq_en;
    logic [1:0] irq_en_next;
    logic       irq_q;

    assign wr_irq_en   = mmio_wr & (off == OFF_IRQ_EN);
    assign irq_en_next = wr_irq_en ? proc_data[1:0] : irq_en;
    assign irq_en_rd   = irq_en;
    assign irq         = irq_q;

    // irq reflects the FIFO/OVF state that results from this same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_en <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            irq_en <= irq_en_next;
            irq_q  <= (irq_en_next[0] & (count_next != '0)) | (irq_en_next[1] & ovf_next);
        end
    end
`else
    assign irq_en_rd = 2'b00;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: queue-based reference model checked every cycle,
// plus directed literal checks. Honours MMIO_IRQ_EN when defined.
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [11:0] proc_address;
    logic [31:0] proc_data;
    logic        proc_wren;
    logic [31:0] proc_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        irq;

    int pass_count  = 0;
    int check_count = 0;

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .proc_address (proc_address),
        .proc_data    (proc_data),
        .proc_wren    (proc_wren),
        .proc_q       (proc_q),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached dmem: one-cycle synchronous read, read-before-write.
    logic [31:0] ram [4096];
    initial for (int i = 0; i < 4096; i++) ram[i] = '0;
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    // Reference model state.
    bit               model_valid = 0;
    int unsigned      model_mem [int unsigned];
    int unsigned      fifo [$];
    int unsigned      m_cycle;
    int unsigned      m_scratch;
    bit               m_ovf;
    bit [1:0]         m_irq_en;
    int unsigned      exp_q;

    function automatic int unsigned mem_read(input int unsigned a);
        return model_mem.exists(a) ? model_mem[a] : 0;
    endfunction

    function automatic int unsigned status_value();
        int unsigned n = fifo.size();
        return (m_ovf ? 32'h100 : 0) + (n << 2) + ((n == 8) ? 2 : 0) + ((n == 0) ? 1 : 0);
    endfunction

    function automatic bit exp_irq();
`ifdef MMIO_IRQ_EN
        return (m_irq_en[0] && fifo.size() != 0) || (m_irq_en[1] && m_ovf);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clock) begin
        int unsigned rd;
        int unsigned addr;
        int          off;
        bit          mmio, wr, pop, push, ovfl;
        addr = proc_address;
        mmio = (proc_address[11:4] == 8'hFF);
        off  = proc_address[3:0];
        rd   = mem_read(addr);
        if (proc_wren && !mmio) model_mem[addr] = proc_data;
        if (!reset) begin
            m_cycle = 0;
            m_scratch = 0;
            m_ovf = 0;
            m_irq_en = 0;
            fifo.delete();
            exp_q = rd;
            model_valid = 1;
        end else begin
            if (mmio) begin
                case (off)
                    0: rd = m_cycle;
                    2: rd = status_value();
                    3: rd = m_scratch;
`ifdef MMIO_IRQ_EN
                    4: rd = m_irq_en;
`endif
                    default: rd = 0;
                endcase
            end
            wr   = proc_wren && mmio;
            pop  = (fifo.size() != 0) && tx_ready;
            push = wr && off == 1 && (fifo.size() < 8 || pop);
            ovfl = wr && off == 1 && fifo.size() == 8 && !pop;
            if (pop) void'(fifo.pop_front());
            if (push) fifo.push_back(proc_data);
            if (wr && off == 2 && proc_data[8]) m_ovf = 0;
            if (ovfl) m_ovf = 1;
            m_cycle = (wr && off == 0) ? 0 : m_cycle + 1;
            if (wr && off == 3) m_scratch = proc_data;
`ifdef MMIO_IRQ_EN
            if (wr && off == 4) m_irq_en = proc_data[1:0];
`endif
            exp_q = rd;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("proc_q", proc_q, exp_q);
            checkOutput("tx_valid", 32'(tx_valid), 32'(fifo.size() != 0));
            if (fifo.size() != 0) checkOutput("tx_data", tx_data, fifo[0]);
            checkOutput("irq", 32'(irq), 32'(exp_irq()));
            checkOutput("mem_wren", 32'(mem_wren), 32'(proc_wren && proc_address[11:4] != 8'hFF));
            checkOutput("mem_address", 32'(mem_address), 32'(proc_address));
            checkOutput("mem_data", mem_data, proc_data);
        end
    end

    task automatic setInputs(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
        proc_address = a;
        proc_data    = d;
        proc_wren    = w;
        tx_ready     = r;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
        setInputs(a, d, w, r);
        step();
    endtask

    initial begin
        int unsigned drain2 [8];
        reset = 1'b0;
        setInputs(12'h000, 32'h0, 1'b0, 1'b0);

        $display("[TB] reset and cycle counter");
        step();
        step();
        reset = 1'b1;
        repeat (9) applyStimulus(12'h000, 32'h0, 1'b0, 1'b0);
        applyStimulus(12'hFF0, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_read", proc_q, 32'd9);
        checkOutput("tx_valid_idle", 32'(tx_valid), 32'd0);

        $display("[TB] dmem pass-through and scratch");
        setInputs(12'h010, 32'h5A, 1'b1, 1'b0);
        #1 checkOutput("mem_wren_dmem", 32'(mem_wren), 32'd1);
        step();
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b0);
        checkOutput("dmem_read", proc_q, 32'h5A);
        setInputs(12'hFF3, 32'h7, 1'b1, 1'b0);
        #1 checkOutput("mem_wren_mmio", 32'(mem_wren), 32'd0);
        step();
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        checkOutput("scratch_read", proc_q, 32'h7);

        $display("[TB] fill past full, then drain");
        for (int i = 1; i <= 9; i++) applyStimulus(12'hFF1, 32'(i), 1'b1, 1'b0);
        applyStimulus(12'hFF2, 32'h0, 1'b0, 1'b0);
        checkOutput("status_full_ovf", proc_q, 32'h122);
        for (int i = 1; i <= 8; i++) begin
            setInputs(12'h000, 32'h0, 1'b0, 1'b1);
            checkOutput("drain_data", tx_data, 32'(i));
            step();
        end
        checkOutput("tx_valid_drained", 32'(tx_valid), 32'd0);
        applyStimulus(12'hFF2, 32'h0, 1'b0, 1'b1);
        checkOutput("status_empty_ovf", proc_q, 32'h101);

        $display("[TB] clear OVF, push while full with pop");
        applyStimulus(12'hFF2, 32'h100, 1'b1, 1'b1);
        applyStimulus(12'hFF2, 32'h0, 1'b0, 1'b1);
        checkOutput("status_cleared", proc_q, 32'h001);
        for (int i = 11; i <= 18; i++) applyStimulus(12'hFF1, 32'(i), 1'b1, 1'b0);
        applyStimulus(12'hFF1, 32'hAA, 1'b1, 1'b1);
        applyStimulus(12'hFF2, 32'h0, 1'b0, 1'b0);
        checkOutput("status_full_no_ovf", proc_q, 32'h022);
        for (int i = 0; i < 7; i++) drain2[i] = 32'(12 + i);
        drain2[7] = 32'hAA;
        for (int i = 0; i < 8; i++) begin
            setInputs(12'h000, 32'h0, 1'b0, 1'b1);
            checkOutput("drain_with_aa", tx_data, drain2[i]);
            step();
        end

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++) applyStimulus(12'hFF1, 32'(32'h21 + i), 1'b1, 1'b0);
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b1);
        reset = 1'b0;
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b1);
        checkOutput("tx_valid_after_reset", 32'(tx_valid), 32'd0);
        reset = 1'b1;
        applyStimulus(12'hFF2, 32'h0, 1'b0, 1'b0);
        checkOutput("status_after_reset", proc_q, 32'h001);

        $display("[TB] cycle clear, unused offset, irq");
        applyStimulus(12'hFF0, 32'h1234, 1'b1, 1'b0);
        applyStimulus(12'hFF0, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_after_clear", proc_q, 32'd0);
        applyStimulus(12'hFF5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(12'hFF5, 32'h0, 1'b0, 1'b0);
        checkOutput("unused_offset", proc_q, 32'd0);
        applyStimulus(12'hFF4, 32'h1, 1'b1, 1'b0);
        applyStimulus(12'hFF1, 32'h77, 1'b1, 1'b0);
`ifdef MMIO_IRQ_EN
        checkOutput("irq_after_push", 32'(irq), 32'd1);
`else
        checkOutput("irq_after_push", 32'(irq), 32'd0);
`endif
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b1);
        checkOutput("irq_after_pop", 32'(irq), 32'd0);
        applyStimulus(12'hFF4, 32'h0, 1'b0, 1'b0);
`ifdef MMIO_IRQ_EN
        checkOutput("irq_en_read", proc_q, 32'd1);
`else
        checkOutput("irq_en_read", proc_q, 32'd0);
`endif

        repeat (3) applyStimulus(12'h000, 32'h0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
